// File: rtl/ysyx_23060042_lsu.sv
// ysyx_23060042_lsu: single-transaction load/store unit with alignment checks,
// byte-lane steering, load extension and a REQ+WAIT timeout.
module ysyx_23060042_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    input  logic        ren,
    input  logic        wen,
    input  logic [1:0]  size,
    input  logic        unsign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] mrdata,
    output logic        err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_wen,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_resp_err
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, wdata_q, mrdata_q, mrdata_d;
    logic [1:0]    size_q;
    logic          ren_q, wen_q, uns_q, err_q, err_d;
    logic          accept, misaligned, timeout;
    logic [7:0]    lb;
    logic [15:0]   lh;
    logic [31:0]   ld;

    assign in_ready   = state_q == IDLE && !rst;
    assign accept     = in_valid && in_ready;
    assign misaligned = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    assign timeout    = cnt_q == CW'(TIMEOUT - 1);

    assign lb = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lh = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    assign ld = size_q == 2'b00 ? {{24{lb[7] & ~uns_q}}, lb} :
                size_q == 2'b01 ? {{16{lh[15] & ~uns_q}}, lh} : bus_rdata;

    // The request is withdrawn in the timeout cycle so an aborted op never handshakes.
    assign bus_req_valid = state_q == REQ && !timeout;
    assign bus_addr      = {addr_q[31:2], 2'b00};
    assign bus_wen       = wen_q;
    assign bus_wdata     = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
                           size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign bus_wstrb     = !wen_q ? 4'b0000 :
                           size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                           size_q == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;

    assign out_valid = state_q == RESP;
    assign mrdata    = mrdata_q;
    assign err       = err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mrdata_d = mrdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (accept) begin
                mrdata_d = '0;
                err_d    = (ren || wen) && misaligned;
                state_d  = (ren || wen) && !misaligned ? REQ : RESP;
                cnt_d    = '0;
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (timeout) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (bus_req_ready) state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bus_resp_valid) begin
                    state_d  = RESP;
                    err_d    = bus_resp_err;
                    mrdata_d = ren_q && !bus_resp_err ? ld : '0;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            RESP: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mrdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mrdata_q <= mrdata_d;
            err_q    <= err_d;
        end
        if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata_in;
            ren_q   <= ren;
            wen_q   <= wen;
            size_q  <= size;
            uns_q   <= unsign;
        end
    end
endmodule
